stack_op_sequencer: RTL and testbench

STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

---
 rtl/stack_pkg.sv | 24 ++
 rtl/stack_op_sequencer_btn_decode.sv | 24 ++
 rtl/stack_op_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack operation sequencer: FSM encodings,
// button index and the operand-count helper.
package stack_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_POP_B    = 3'd1;
  localparam logic [2:0] S_POP_A    = 3'd2;
  localparam logic [2:0] S_ALU_WAIT = 3'd3;
  localparam logic [2:0] S_PUSH     = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;

  localparam int BTN_PUSH = 0;

  // An op consumes one operand when its unary-mask bit is set, otherwise two.
  function automatic logic [1:0] operand_count(input logic [31:0] unary_mask,
                                               input logic [31:0] op_onehot);
    if ((unary_mask & op_onehot) != 32'd0) begin
      operand_count = 2'd1;
    end else begin
      operand_count = 2'd2;
    end
  endfunction

endpackage

// File: rtl/stack_op_sequencer_btn_decode.sv
// Button decoder: flags a single pressed button and splits it into the
// push flag and a one-hot operation select.
module btn_decode
  import stack_pkg::*;
#(
  parameter int NUM_OPS = 4
) (
  input  logic [NUM_OPS:0]   btns,
  output logic               valid,
  output logic               is_push,
  output logic [NUM_OPS-1:0] op_onehot
);

  localparam int BW = NUM_OPS + 1;

  logic single;

  // x & (x-1) clears the lowest set bit, so it is zero only for one-hot x.
  assign single    = (btns != BW'(0)) && ((btns & (btns - BW'(1))) == BW'(0));
  assign valid     = single;
  assign is_push   = single & btns[BTN_PUSH];
  assign op_onehot = single ? btns[NUM_OPS:1] : {NUM_OPS{1'b0}};

endmodule

// File: rtl/stack_op_sequencer.sv
// Sequences push/pop/ALU operations on an external stack from debounced
// front-panel buttons; every output is registered.
module stack_op_sequencer
  import stack_pkg::*;
#(
  parameter int                   DATA_W     = 32,
  parameter int                   SW_W       = 16,
  parameter int                   NUM_OPS    = 4,
  parameter int                   DEPTH      = 16,
  parameter logic [NUM_OPS-1:0]   UNARY_MASK = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SW_W-1:0]              switches,
  input  logic [NUM_OPS:0]             btns,
  input  logic [DATA_W-1:0]            mem_rd_data,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic                         alu_done,
  output logic                         push,
  output logic                         pop,
  output logic [DATA_W-1:0]            mem_wr_data,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  output logic [NUM_OPS-1:0]           alu_op,
  output logic                         alu_start,
  output logic                         busy,
  output logic                         err_underflow,
  output logic                         err_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int              DW         = $clog2(DEPTH + 1);
  localparam logic [DW-1:0]   DEPTH_FULL = DW'(DEPTH);

  logic               btn_valid;
  logic               btn_push;
  logic [NUM_OPS-1:0] btn_op;
  logic [1:0]         btn_need;
  logic               cur_unary;

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [DW-1:0]      depth_next;
  logic               push_next;
  logic               pop_next;
  logic [DATA_W-1:0]  wr_data_next;
  logic [DATA_W-1:0]  alu_a_next;
  logic [DATA_W-1:0]  alu_b_next;
  logic [NUM_OPS-1:0] alu_op_next;
  logic               alu_start_next;
  logic               err_uf_next;
  logic               err_of_next;

  btn_decode #(
    .NUM_OPS (NUM_OPS)
  ) u_btn_decode (
    .btns      (btns),
    .valid     (btn_valid),
    .is_push   (btn_push),
    .op_onehot (btn_op)
  );

  assign btn_need  = operand_count(32'(UNARY_MASK), 32'(btn_op));
  // Mid-sequence decisions use the latched op so button changes cannot disturb them.
  assign cur_unary = (alu_op & UNARY_MASK) != {NUM_OPS{1'b0}};

  // Next-state and next-output computation for the sequencer FSM.
  always_comb begin
    state_next     = state;
    depth_next     = depth;
    push_next      = 1'b0;
    pop_next       = 1'b0;
    wr_data_next   = mem_wr_data;
    alu_a_next     = alu_a;
    alu_b_next     = alu_b;
    alu_op_next    = alu_op;
    alu_start_next = 1'b0;
    err_uf_next    = 1'b0;
    err_of_next    = 1'b0;

    case (state)
      S_IDLE: begin
        if (btn_valid) begin
          if (btn_push) begin
            if (depth < DEPTH_FULL) begin
              wr_data_next = DATA_W'(switches);
              push_next    = 1'b1;
              depth_next   = depth + DW'(1);
              state_next   = S_PUSH;
            end else begin
              err_of_next  = 1'b1;
              state_next   = S_HOLD;
            end
          end else begin
            if (depth < DW'(btn_need)) begin
              err_uf_next  = 1'b1;
              state_next   = S_HOLD;
            end else begin
              alu_op_next  = btn_op;
              pop_next     = 1'b1;
              state_next   = S_POP_B;
            end
          end
        end else begin
          state_next = S_IDLE;
        end
      end

      S_POP_B: begin
        depth_next = depth - DW'(1);
        if (cur_unary) begin
          alu_a_next     = mem_rd_data;
          alu_b_next     = {DATA_W{1'b0}};
          alu_start_next = 1'b1;
          state_next     = S_ALU_WAIT;
        end else begin
          alu_b_next     = mem_rd_data;
          pop_next       = 1'b1;
          state_next     = S_POP_A;
        end
      end

      S_POP_A: begin
        alu_a_next     = mem_rd_data;
        depth_next     = depth - DW'(1);
        alu_start_next = 1'b1;
        state_next     = S_ALU_WAIT;
      end

      S_ALU_WAIT: begin
        // alu_done is ignored during the alu_start cycle itself.
        if (alu_start) begin
          state_next = S_ALU_WAIT;
        end else if (alu_done) begin
          wr_data_next = alu_result;
          push_next    = 1'b1;
          depth_next   = depth + DW'(1);
          state_next   = S_PUSH;
        end else begin
          state_next = S_ALU_WAIT;
        end
      end

      S_PUSH: begin
        alu_op_next = {NUM_OPS{1'b0}};
        state_next  = S_HOLD;
      end

      S_HOLD: begin
        if (btns == {(NUM_OPS + 1){1'b0}}) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_HOLD;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, asynchronously cleared by rst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      depth         <= {DW{1'b0}};
      push          <= 1'b0;
      pop           <= 1'b0;
      mem_wr_data   <= {DATA_W{1'b0}};
      alu_a         <= {DATA_W{1'b0}};
      alu_b         <= {DATA_W{1'b0}};
      alu_op        <= {NUM_OPS{1'b0}};
      alu_start     <= 1'b0;
      busy          <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state         <= state_next;
      depth         <= depth_next;
      push          <= push_next;
      pop           <= pop_next;
      mem_wr_data   <= wr_data_next;
      alu_a         <= alu_a_next;
      alu_b         <= alu_b_next;
      alu_op        <= alu_op_next;
      alu_start     <= alu_start_next;
      busy          <= (state_next != S_IDLE);
      err_underflow <= err_uf_next;
      err_overflow  <= err_of_next;
    end
  end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed self-checking bench for stack_op_sequencer with a small stack
// memory model driving mem_rd_data.
module tb_stack_op_sequencer;

  localparam int DATA_W  = 32;
  localparam int SW_W    = 16;
  localparam int NUM_OPS = 4;
  localparam int DEPTH   = 16;

  logic                 clk;
  logic                 rst;
  logic [SW_W-1:0]      switches;
  logic [NUM_OPS:0]     btns;
  logic [DATA_W-1:0]    mem_rd_data;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_done;
  logic                 push;
  logic                 pop;
  logic [DATA_W-1:0]    mem_wr_data;
  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic [NUM_OPS-1:0]   alu_op;
  logic                 alu_start;
  logic                 busy;
  logic                 err_underflow;
  logic                 err_overflow;
  logic [4:0]           depth;

  int checks = 0;
  int fails  = 0;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  int sp;

  stack_op_sequencer #(
    .DATA_W     (DATA_W),
    .SW_W       (SW_W),
    .NUM_OPS    (NUM_OPS),
    .DEPTH      (DEPTH),
    .UNARY_MASK (4'b0010)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .switches      (switches),
    .btns          (btns),
    .mem_rd_data   (mem_rd_data),
    .alu_result    (alu_result),
    .alu_done      (alu_done),
    .push          (push),
    .pop           (pop),
    .mem_wr_data   (mem_wr_data),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_start     (alu_start),
    .busy          (busy),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow),
    .depth         (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External stack memory model, cleared by the same reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= 0;
    end else if (push && sp < DEPTH) begin
      mem[sp] <= mem_wr_data;
      sp      <= sp + 1;
    end else if (pop && sp > 0) begin
      sp <= sp - 1;
    end
  end

  always_comb begin
    mem_rd_data = '0;
    if (sp > 0) mem_rd_data = mem[sp-1];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_push(input logic [15:0] val, input int exp_depth);
    switches = val;
    btns     = 5'b00001;
    tick();
    check("push_pulse", 32'(push), 32'd1);
    check("push_data", mem_wr_data, {16'h0000, val});
    check("push_depth", 32'(depth), 32'(exp_depth));
    tick();
    check("push_hold_strobe", 32'(push), 32'd0);
    check("push_hold_busy", 32'(busy), 32'd1);
    btns = 5'b00000;
    tick();
    check("push_release_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    switches   = '0;
    btns       = '0;
    alu_result = '0;
    alu_done   = 1'b0;
    tick();
    tick();
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_push", 32'(push), 32'd0);
    check("rst_wr_data", mem_wr_data, 32'd0);
    rst = 1'b1;
    tick();

    // First push, with HOLD persisting while the button stays down.
    switches = 16'h0005;
    btns     = 5'b00001;
    tick();
    check("p5_pulse", 32'(push), 32'd1);
    check("p5_data", mem_wr_data, 32'h0000_0005);
    check("p5_depth", 32'(depth), 32'd1);
    tick();
    check("p5_hold_push", 32'(push), 32'd0);
    tick();
    check("p5_hold_busy", 32'(busy), 32'd1);
    btns = 5'b00000;
    tick();
    check("p5_idle", 32'(busy), 32'd0);

    rst = 1'b0;
    tick();
    check("rst2_depth", 32'(depth), 32'd0);
    rst = 1'b1;
    tick();

    // Binary op1 on 3,7; buttons released mid-sequence must not abort it.
    press_push(16'h0003, 1);
    press_push(16'h0007, 2);
    btns = 5'b00010;
    tick();
    check("bin_popb", 32'(pop), 32'd1);
    check("bin_op", 32'(alu_op), 32'h1);
    btns = 5'b00000;
    tick();
    check("bin_popa", 32'(pop), 32'd1);
    check("bin_b", alu_b, 32'd7);
    check("bin_depth1", 32'(depth), 32'd1);
    tick();
    check("bin_pop_off", 32'(pop), 32'd0);
    check("bin_start", 32'(alu_start), 32'd1);
    check("bin_a", alu_a, 32'd3);
    check("bin_depth0", 32'(depth), 32'd0);
    alu_result = 32'd10;
    alu_done   = 1'b1;
    tick();
    check("bin_start_off", 32'(alu_start), 32'd0);
    check("bin_no_early_push", 32'(push), 32'd0);
    tick();
    alu_done = 1'b0;
    check("bin_push", 32'(push), 32'd1);
    check("bin_result", mem_wr_data, 32'h0000_000A);
    check("bin_depth_end", 32'(depth), 32'd1);
    check("bin_op_held", 32'(alu_op), 32'h1);
    tick();
    check("bin_push_off", 32'(push), 32'd0);
    check("bin_hold_busy", 32'(busy), 32'd1);
    tick();
    check("bin_idle", 32'(busy), 32'd0);

    // Unary op2 with a slow ALU.
    btns = 5'b00100;
    tick();
    check("un_pop", 32'(pop), 32'd1);
    check("un_op", 32'(alu_op), 32'h2);
    btns = 5'b00000;
    tick();
    check("un_single_pop", 32'(pop), 32'd0);
    check("un_start", 32'(alu_start), 32'd1);
    check("un_b_zero", alu_b, 32'd0);
    check("un_a", alu_a, 32'd10);
    check("un_depth0", 32'(depth), 32'd0);
    tick();
    tick();
    tick();
    check("un_wait_busy", 32'(busy), 32'd1);
    check("un_wait_nopush", 32'(push), 32'd0);
    alu_result = 32'hFFFF_FFF5;
    alu_done   = 1'b1;
    tick();
    alu_done = 1'b0;
    check("un_push", 32'(push), 32'd1);
    check("un_result", mem_wr_data, 32'hFFFF_FFF5);
    check("un_depth", 32'(depth), 32'd1);
    tick();
    tick();
    check("un_idle", 32'(busy), 32'd0);

    // Underflow: binary op with one word on the stack.
    btns = 5'b00010;
    tick();
    check("uf_pulse", 32'(err_underflow), 32'd1);
    check("uf_nopop", 32'(pop), 32'd0);
    check("uf_depth", 32'(depth), 32'd1);
    tick();
    check("uf_pulse_end", 32'(err_underflow), 32'd0);
    check("uf_hold", 32'(busy), 32'd1);
    btns = 5'b00000;
    tick();

    // Fill to capacity, then one push too many.
    for (int i = 2; i <= DEPTH; i++) begin
      press_push(16'(i), i);
    end
    switches = 16'h1234;
    btns     = 5'b00001;
    tick();
    check("of_pulse", 32'(err_overflow), 32'd1);
    check("of_nopush", 32'(push), 32'd0);
    check("of_depth", 32'(depth), 32'd16);
    tick();
    check("of_pulse_end", 32'(err_overflow), 32'd0);
    check("of_model_sp", 32'(sp), 32'd16);
    btns = 5'b00000;
    tick();

    // Two buttons at once are ignored.
    btns = 5'b00011;
    tick();
    tick();
    check("multi_busy", 32'(busy), 32'd0);
    check("multi_push", 32'(push), 32'd0);
    check("multi_pop", 32'(pop), 32'd0);
    check("multi_depth", 32'(depth), 32'd16);
    btns = 5'b00000;
    tick();

    // Asynchronous reset while waiting on the ALU.
    btns = 5'b00010;
    tick();
    btns = 5'b00000;
    tick();
    tick();
    check("mid_start", 32'(alu_start), 32'd1);
    tick();
    check("mid_waiting", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_depth", 32'(depth), 32'd0);
    check("mid_rst_a", alu_a, 32'd0);
    check("mid_rst_b", alu_b, 32'd0);
    check("mid_rst_op", 32'(alu_op), 32'd0);
    check("mid_rst_data", mem_wr_data, 32'd0);
    check("mid_rst_start", 32'(alu_start), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
